// File: rtl/data_mem_ctrl.sv
// Purpose : data-side memory responder; serialises MEM-stage load/store requests into byte accesses on an 8-bit sync RAM.
// Latency : load N bytes -> mem_enable in cycle N+2; store N bytes -> mem_enable in cycle N+1 (cycle 0 = first IDLE cycle with a flag high).
// Backpressure: none on the request side (requester holds its flag until mem_enable); with IO_STALL_EN, io_full holds IO-region store bytes.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   mem_addr_i            request byte address (sampled when num_of_bytes != 0)
//   num_of_bytes          request size 1/2/4; nonzero marks the capture cycle
//   store_data            store data, byte k goes to address+k
//   load_or_not           load request flag, held until mem_enable
//   store_or_not          store request flag, held until mem_enable (wins over load)
//   load_data             assembled little-endian load result, zero-extended
//   mem_enable            one-cycle completion pulse
//   ram_a/ram_wr/ram_dout RAM byte address, write strobe, write byte
//   ram_din               RAM read byte, one cycle after the address
//   io_full               IO write buffer full (only with IO_STALL_EN)
//
// Configuration macro: IO_STALL_EN -- when defined, store byte cycles to an
// address with addr[17:16] == 2'b11 are held while io_full is high.

module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  num_of_bytes,
  input  logic [31:0] store_data,
  input  logic        load_or_not,
  input  logic        store_or_not,
  output logic [31:0] load_data,
  output logic        mem_enable,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  input  logic        io_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Registered state
  state_t      r_state;
  logic [31:0] r_addr;       // latched request address
  logic [1:0]  r_last;       // latched byte count minus one
  logic [31:0] r_sdata;      // latched store data
  logic [1:0]  r_idx;        // byte index currently on the RAM port
  logic        r_issue;      // load: an address is on ram_a this cycle
  logic        r_rx_vld;     // load: ram_din carries a requested byte this cycle
  logic [1:0]  r_rx_idx;     // load: byte lane for the byte on ram_din
  logic [31:0] r_load_data;
  logic        r_mem_enable;
  logic [31:0] r_ram_a;
  logic        r_ram_wr;
  logic [7:0]  r_ram_dout;

  // Next-state values
  state_t      w_state_nxt;
  logic [31:0] w_addr_nxt;
  logic [1:0]  w_last_nxt;
  logic [31:0] w_sdata_nxt;
  logic [1:0]  w_idx_nxt;
  logic        w_issue_nxt;
  logic        w_rx_vld_nxt;
  logic [1:0]  w_rx_idx_nxt;
  logic [31:0] w_load_data_nxt;
  logic        w_mem_enable_nxt;
  logic [31:0] w_ram_a_nxt;
  logic        w_ram_wr_nxt;
  logic [7:0]  w_ram_dout_nxt;

  // Request capture: a start in the same cycle as the capture must see the
  // live request, so the effective values bypass the capture registers.
  logic        w_cap;
  logic [1:0]  w_cap_last;
  logic [31:0] w_eff_addr;
  logic [1:0]  w_eff_last;
  logic [31:0] w_eff_sdata;

  logic [1:0]  w_idx_inc;
  logic [1:0]  w_idx_adv;
  logic [7:0]  w_store_byte;
  logic        w_hold_start;
  logic        w_hold_run;

  assign w_cap       = (num_of_bytes != 3'd0);
  assign w_cap_last  = num_of_bytes[2] ? 2'd3 : (num_of_bytes[1] ? 2'd1 : 2'd0);
  assign w_eff_addr  = w_cap ? mem_addr_i : r_addr;
  assign w_eff_last  = w_cap ? w_cap_last : r_last;
  assign w_eff_sdata = w_cap ? store_data : r_sdata;

  assign w_idx_inc    = r_idx + 2'd1;
  // A store byte index only advances after a cycle that actually wrote.
  assign w_idx_adv    = r_ram_wr ? w_idx_inc : r_idx;
  assign w_store_byte = r_sdata[{w_idx_adv, 3'b000} +: 8];

`ifdef IO_STALL_EN
  // Hold decisions are registered: io_full in cycle c suppresses the write in c+1.
  assign w_hold_start = io_full && (w_eff_addr[17:16] == 2'b11);
  assign w_hold_run   = io_full && (r_addr[17:16] == 2'b11);
`else
  logic w_io_full_unused;
  assign w_io_full_unused = io_full;
  assign w_hold_start     = 1'b0;
  assign w_hold_run       = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_last_nxt       = r_last;
    w_sdata_nxt      = r_sdata;
    w_idx_nxt        = r_idx;
    w_issue_nxt      = 1'b0;
    w_rx_vld_nxt     = 1'b0;
    w_rx_idx_nxt     = r_rx_idx;
    w_load_data_nxt  = r_load_data;
    w_mem_enable_nxt = 1'b0;
    w_ram_a_nxt      = 32'd0;
    w_ram_wr_nxt     = 1'b0;
    w_ram_dout_nxt   = 8'd0;

    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_addr_nxt  = mem_addr_i;
          w_last_nxt  = w_cap_last;
          w_sdata_nxt = store_data;
        end
        if (store_or_not) begin
          w_state_nxt = S_STORE;
          w_idx_nxt   = 2'd0;
          if (!w_hold_start) begin
            w_ram_a_nxt    = w_eff_addr;
            w_ram_wr_nxt   = 1'b1;
            w_ram_dout_nxt = w_eff_sdata[7:0];
          end
        end else if (load_or_not) begin
          w_state_nxt     = S_LOAD;
          w_idx_nxt       = 2'd0;
          w_issue_nxt     = 1'b1;
          w_ram_a_nxt     = w_eff_addr;
          w_load_data_nxt = 32'd0;
        end
      end

      S_LOAD: begin
        // Address pipeline runs one cycle ahead of the returning data.
        if (r_rx_vld) begin
          w_load_data_nxt[{r_rx_idx, 3'b000} +: 8] = ram_din;
        end
        w_rx_vld_nxt = r_issue;
        w_rx_idx_nxt = r_idx;
        if (r_issue && (r_idx != r_last)) begin
          w_idx_nxt   = w_idx_inc;
          w_issue_nxt = 1'b1;
          w_ram_a_nxt = r_addr + {30'd0, w_idx_inc};
        end
        if (r_rx_vld && (r_rx_idx == r_last)) begin
          w_state_nxt      = S_DONE;
          w_mem_enable_nxt = 1'b1;
        end
      end

      S_STORE: begin
        if (r_ram_wr && (r_idx == r_last)) begin
          w_state_nxt      = S_DONE;
          w_mem_enable_nxt = 1'b1;
        end else begin
          w_idx_nxt = w_idx_adv;
          if (!w_hold_run) begin
            w_ram_a_nxt    = r_addr + {30'd0, w_idx_adv};
            w_ram_wr_nxt   = 1'b1;
            w_ram_dout_nxt = w_store_byte;
          end
        end
      end

      S_DONE: begin
        // Request flags are still high here; they are deliberately ignored.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'd0;
      r_last       <= 2'd0;
      r_sdata      <= 32'd0;
      r_idx        <= 2'd0;
      r_issue      <= 1'b0;
      r_rx_vld     <= 1'b0;
      r_rx_idx     <= 2'd0;
      r_load_data  <= 32'd0;
      r_mem_enable <= 1'b0;
      r_ram_a      <= 32'd0;
      r_ram_wr     <= 1'b0;
      r_ram_dout   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_last       <= w_last_nxt;
      r_sdata      <= w_sdata_nxt;
      r_idx        <= w_idx_nxt;
      r_issue      <= w_issue_nxt;
      r_rx_vld     <= w_rx_vld_nxt;
      r_rx_idx     <= w_rx_idx_nxt;
      r_load_data  <= w_load_data_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_ram_a      <= w_ram_a_nxt;
      r_ram_wr     <= w_ram_wr_nxt;
      r_ram_dout   <= w_ram_dout_nxt;
    end
  end

  assign load_data  = r_load_data;
  assign mem_enable = r_mem_enable;
  assign ram_a      = r_ram_a;
  assign ram_wr     = r_ram_wr;
  assign ram_dout   = r_ram_dout;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: table of request vectors with hand-derived
// completion latency and load data, a byte-wide RAM model, and a queue of
// expected completions popped whenever mem_enable pulses.

module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr_i;
  logic [2:0]  num_of_bytes;
  logic [31:0] store_data;
  logic        load_or_not;
  logic        store_or_not;
  logic [31:0] load_data;
  logic        mem_enable;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        io_full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr_i   (mem_addr_i),
    .num_of_bytes (num_of_bytes),
    .store_data   (store_data),
    .load_or_not  (load_or_not),
    .store_or_not (store_or_not),
    .load_data    (load_data),
    .mem_enable   (mem_enable),
    .ram_a        (ram_a),
    .ram_wr       (ram_wr),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din),
    .io_full      (io_full)
  );

  // Power-on RAM contents: 0x11,0x22,0x33,0x44 at 0x1000..0x1003, else addr[7:0]^0xC3.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [3:0] n;
    n = {2'b00, a[1:0]} + 4'd1;
    if (a[31:2] == 30'h0000_0400) return {n, n};
    return a[7:0] ^ 8'hC3;
  endfunction

  // Synchronous RAM: read data for the address of cycle k appears in cycle k+1.
  logic [7:0] ram [logic [31:0]];
  always @(posedge clk) begin
    if (ram.exists(ram_a)) ram_din <= ram[ram_a];
    else                   ram_din <= init_byte(ram_a);
    if (ram_wr) ram[ram_a] = ram_dout;
  end

  typedef struct {
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [2:0]  nb;
    logic [31:0] sd;
    int          io_cyc;   // io_full high for cycles 0..io_cyc-1
    int          lat;      // nominal completion cycle
    logic [31:0] exp_ld;   // load_data at completion
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] ld;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[13];

  function automatic vec_t mk(input logic st, input logic ld, input logic [31:0] addr,
                              input logic [2:0] nb, input logic [31:0] sd, input int io_cyc,
                              input int lat, input logic [31:0] exp_ld);
    vec_t v;
    v.st = st; v.ld = ld; v.addr = addr; v.nb = nb; v.sd = sd;
    v.io_cyc = io_cyc; v.lat = lat; v.exp_ld = exp_ld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("no_spurious_enable", {31'd0, mem_enable}, 32'd0);
    end
  endtask

  task automatic run(input vec_t v);
    int          n;
    int          off;
    int          c0;
    int          k;
    bit          done;
    exp_t        e;
    logic [31:0] sh;
    n   = v.nb[2] ? 4 : (v.nb[1] ? 2 : 1);
    off = 0;
`ifdef IO_STALL_EN
    if (v.st && (v.addr[17:16] == 2'b11)) off = v.io_cyc;
`endif
    @(posedge clk); #1;
    mem_addr_i   = v.addr;
    num_of_bytes = v.nb;
    store_data   = v.sd;
    store_or_not = v.st;
    load_or_not  = v.ld;
    io_full      = (v.io_cyc > 0);
    c0 = cyc;
    e.cyc = c0 + v.lat + off;
    e.ld  = v.exp_ld;
    sbq.push_back(e);
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        // Request inputs are only valid in the capture cycle; scramble them.
        num_of_bytes = 3'd0;
        mem_addr_i   = ~v.addr;
        store_data   = ~v.sd;
        io_full      = (c < v.io_cyc);
      end
      @(negedge clk);
      if (c > 0) begin
        k = c - 1 - off;
        if (k >= 0 && k < n) begin
          chk("ram_a", ram_a, v.addr + k);
          chk("ram_wr", {31'd0, ram_wr}, {31'd0, v.st});
          if (v.st) begin
            sh = v.sd >> (8 * k);
            chk("ram_dout", {24'd0, ram_dout}, {24'd0, sh[7:0]});
          end
        end else begin
          chk("ram_wr_quiet", {31'd0, ram_wr}, 32'd0);
        end
      end
      if (mem_enable) begin
        done = 1;
        if (sbq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_enable at cycle %0d: got 1, expected 0", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("load_data", load_data, e.ld);
          chk("ram_a_at_done", ram_a, 32'd0);
          chk("ram_dout_at_done", {24'd0, ram_dout}, 32'd0);
        end
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL completion_timeout at cycle %0d: got no mem_enable, expected one by cycle %0d", cyc, e.cyc);
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    // st ld addr nb data io lat exp_load_data
    tbl[0]  = mk(0, 1, 32'h0000_1000, 3'd4, 32'h0,         0, 6, 32'h4433_2211);
    tbl[1]  = mk(1, 0, 32'h0000_0FFE, 3'd2, 32'hDEAD_BEEF, 0, 3, 32'h4433_2211);
    tbl[2]  = mk(0, 1, 32'h0000_0FFE, 3'd4, 32'h0,         0, 6, 32'h2211_BEEF);
    tbl[3]  = mk(0, 1, 32'hFFFF_FFFF, 3'd1, 32'h0,         0, 3, 32'h0000_003C);
    tbl[4]  = mk(1, 0, 32'h0000_0000, 3'd1, 32'h0000_005A, 0, 2, 32'h0000_003C);
    tbl[5]  = mk(0, 1, 32'hFFFF_FFFF, 3'd2, 32'h0,         0, 4, 32'h0000_5A3C);
    tbl[6]  = mk(1, 1, 32'h0000_2000, 3'd4, 32'h0102_0304, 0, 5, 32'h0000_5A3C);
    tbl[7]  = mk(0, 1, 32'h0000_2000, 3'd4, 32'h0,         0, 6, 32'h0102_0304);
    tbl[8]  = mk(1, 0, 32'h0000_2001, 3'd3, 32'h0000_AABB, 0, 3, 32'h0102_0304);
    tbl[9]  = mk(0, 1, 32'h0000_2000, 3'd7, 32'h0,         0, 6, 32'h01AA_BB04);
    tbl[10] = mk(1, 0, 32'h0003_0000, 3'd1, 32'h0000_0077, 3, 2, 32'h01AA_BB04);
    tbl[11] = mk(0, 1, 32'h0003_0000, 3'd1, 32'h0,         3, 3, 32'h0000_0077);
    tbl[12] = mk(0, 1, 32'h0003_0001, 3'd1, 32'h0,         0, 3, 32'h0000_00C2);

    rst = 1'b0; mem_addr_i = 32'd0; num_of_bytes = 3'd0; store_data = 32'd0;
    load_or_not = 1'b0; store_or_not = 1'b0; io_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Consecutive vectors start in the first IDLE cycle after each DONE.
    for (int i = 0; i < 13; i++) run(tbl[i]);

    // Reset in cycle 2 of a word store: two bytes land, no completion.
    @(posedge clk); #1;
    mem_addr_i = 32'h0000_3000; num_of_bytes = 3'd4; store_data = 32'hA1B2_C3D4;
    store_or_not = 1'b1; load_or_not = 1'b0; io_full = 1'b0;
    @(posedge clk); #1;
    num_of_bytes = 3'd0;
    @(negedge clk);
    chk("rst_sw_c1_ram_a", ram_a, 32'h0000_3000);
    chk("rst_sw_c1_ram_wr", {31'd0, ram_wr}, 32'd1);
    chk("rst_sw_c1_dout", {24'd0, ram_dout}, 32'h0000_00D4);
    @(posedge clk); #1;
    rst = 1'b0; store_or_not = 1'b0;
    @(negedge clk);
    chk("rst_sw_c2_ram_a", ram_a, 32'h0000_3001);
    chk("rst_sw_c2_dout", {24'd0, ram_dout}, 32'h0000_00C3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sw_c3_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_sw_c3_ram_a", ram_a, 32'd0);
    chk("rst_sw_c3_mem_enable", {31'd0, mem_enable}, 32'd0);
    chk("rst_sw_c3_load_data", load_data, 32'd0);
    idle_wait(6);
    run(mk(0, 1, 32'h0000_3000, 3'd4, 32'h0, 0, 6, 32'hC0C1_C3D4));

    @(posedge clk); #1;
    load_or_not = 1'b0; store_or_not = 1'b0;
    idle_wait(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
